typed_ndata_type_splitter: RTL and testbench

- Inverse of the ndata-to-typed-ndata merge: takes a typed_ndata stream (data8_t beats plus a per-beat `typ`) and splits it into two streams:
  - a plain ndata stream (data8_t × DATABEAT_SIZE);
  - a ready_valid type stream carrying exactly one type_t token per packet.
- Sits at the egress of typed processing pipelines, ahead of the ndata-to-AXI adapters and the host-side type sideband.
- Both outputs are registered; data path sustains one beat per cycle.

---
 rtl/typed_ndata_type_splitter.sv | 158 +++++++++++++++
 tb/tb_typed_ndata_type_splitter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typed_ndata_type_splitter.sv
// Splits a typed_ndata stream into a plain ndata stream and a one-token-per-packet type stream.
// Data goes through a 2-entry skid buffer; the type token uses a single output register.
module typed_ndata_type_splitter #(
  parameter int unsigned DATABEAT_SIZE = 64,
  parameter int unsigned TYPE_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATABEAT_SIZE*8-1:0] in_data_i,
  input  logic [DATABEAT_SIZE-1:0]   in_keep_i,
  input  logic                       in_last_i,
  input  logic [TYPE_W-1:0]          in_typ_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [DATABEAT_SIZE*8-1:0] out_data_o,
  output logic [DATABEAT_SIZE-1:0]   out_keep_o,
  output logic                       out_last_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [TYPE_W-1:0]          out_type_data_o,
  output logic                       out_type_valid_o,
  input  logic                       out_type_ready_i,
  output logic                       err_type_mismatch_o
);

  localparam int unsigned DATA_W = DATABEAT_SIZE * 8;

  typedef enum logic {S_IDLE, S_BODY} state_e;

  state_e                   state_q, state_d;
  logic [TYPE_W-1:0]        pkt_typ_q, pkt_typ_d;
  logic                     err_q, err_d;

  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic [DATABEAT_SIZE-1:0] out_keep_q, out_keep_d;
  logic                     out_last_q, out_last_d;

  logic                     skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]        skid_data_q, skid_data_d;
  logic [DATABEAT_SIZE-1:0] skid_keep_q, skid_keep_d;
  logic                     skid_last_q, skid_last_d;

  logic                     type_valid_q, type_valid_d;
  logic [TYPE_W-1:0]        type_data_q, type_data_d;

  logic in_fire;
  logic first_beat;

  // A first beat additionally waits for the previous type token to drain.
  assign first_beat = (state_q == S_IDLE);
  assign in_ready_o = !skid_valid_q && (!first_beat || !type_valid_q || out_type_ready_i);
  assign in_fire    = in_valid_i && in_ready_o;

  always_comb begin
    state_d      = state_q;
    pkt_typ_d    = pkt_typ_q;
    err_d        = err_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_keep_d  = skid_keep_q;
    skid_last_d  = skid_last_q;
    type_valid_d = type_valid_q;
    type_data_d  = type_data_q;

    // Output register refills from skid first, then from the input.
    if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_keep_d   = skid_keep_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
        out_keep_d  = in_keep_i;
        out_last_d  = in_last_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
      skid_keep_d  = in_keep_i;
      skid_last_d  = in_last_i;
    end

    if (type_valid_q && out_type_ready_i) begin
      type_valid_d = 1'b0;
    end
    if (in_fire && first_beat) begin
      type_valid_d = 1'b1;
      type_data_d  = in_typ_i;
    end

    case (state_q)
      S_IDLE: begin
        if (in_fire && !in_last_i) begin
          state_d   = S_BODY;
          pkt_typ_d = in_typ_i;
        end
      end
      S_BODY: begin
        if (in_fire) begin
          if (in_typ_i != pkt_typ_q) begin
            err_d = 1'b1;
          end
          if (in_last_i) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      type_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      type_valid_q <= type_valid_d;
    end
  end

  // Payload registers need no reset; their valid flags qualify them.
  always_ff @(posedge clk) begin
    pkt_typ_q   <= pkt_typ_d;
    out_data_q  <= out_data_d;
    out_keep_q  <= out_keep_d;
    out_last_q  <= out_last_d;
    skid_data_q <= skid_data_d;
    skid_keep_q <= skid_keep_d;
    skid_last_q <= skid_last_d;
    type_data_q <= type_data_d;
  end

  assign out_data_o          = out_data_q;
  assign out_keep_o          = out_keep_q;
  assign out_last_o          = out_last_q;
  assign out_valid_o         = out_valid_q;
  assign out_type_data_o     = type_data_q;
  assign out_type_valid_o    = type_valid_q;
  assign err_type_mismatch_o = err_q;

endmodule

// File: tb/tb_typed_ndata_type_splitter.sv
// Directed bench for typed_ndata_type_splitter with beat and token scoreboards.
module tb_typed_ndata_type_splitter;

  localparam int unsigned DB = 64;
  localparam int unsigned DW = DB * 8;
  localparam int unsigned TW = 8;

  localparam logic [TW-1:0] T_A = 8'hA1;
  localparam logic [TW-1:0] T_B = 8'hB2;
  localparam logic [TW-1:0] T_C = 8'hC3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [DB-1:0] in_keep;
  logic          in_last;
  logic [TW-1:0] in_typ;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [DB-1:0] out_keep;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_type_data;
  logic          out_type_valid;
  logic          out_type_ready;
  logic          err;

  int errors = 0;
  int checks = 0;

  beat_t         exp_beats[$];
  logic [TW-1:0] exp_types[$];
  logic          tb_first = 1'b1;
  logic          rand_mode = 1'b0;
  logic          ready_fixed = 1'b1;
  int            tokens_seen = 0;

  typed_ndata_type_splitter #(.DATABEAT_SIZE(DB), .TYPE_W(TW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_data_i           (in_data),
    .in_keep_i           (in_keep),
    .in_last_i           (in_last),
    .in_typ_i            (in_typ),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .out_data_o          (out_data),
    .out_keep_o          (out_keep),
    .out_last_o          (out_last),
    .out_valid_o         (out_valid),
    .out_ready_i         (out_ready),
    .out_type_data_o     (out_type_data),
    .out_type_valid_o    (out_type_valid),
    .out_type_ready_i    (out_type_ready),
    .err_type_mismatch_o (err)
  );

  always #5 clk = ~clk;

  // Downstream data ready: fixed level or 50% random, changed just after each edge.
  always @(posedge clk) begin
    #1;
    out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // Data monitor: pops on handshake, checks hold-while-stalled.
  beat_t prev_beat;
  logic  prev_valid = 1'b0;
  logic  prev_ready = 1'b0;
  always @(negedge clk) begin
    beat_t got;
    beat_t e;
    got = '{data: out_data, keep: out_keep, last: out_last};
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        checks++;
        assert (out_valid === 1'b1 && got === prev_beat) else begin
          errors++;
          $error("FAIL stall_hold obs=%h exp=%h", got, prev_beat);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_beats.size() == 0) begin
          errors++;
          $error("FAIL beat_extra obs=%h exp=none", got);
        end else begin
          e = exp_beats.pop_front();
          assert (got === e) else begin
            errors++;
            $error("FAIL beat obs=%h exp=%h", got, e);
          end
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_beat  = got;
    end
  end

  // Type token monitor.
  always @(negedge clk) begin
    logic [TW-1:0] et;
    if (!rst && out_type_valid && out_type_ready) begin
      checks++;
      tokens_seen++;
      if (exp_types.size() == 0) begin
        errors++;
        $error("FAIL token_extra obs=%h exp=none", out_type_data);
      end else begin
        et = exp_types.pop_front();
        assert (out_type_data === et) else begin
          errors++;
          $error("FAIL token obs=%h exp=%h", out_type_data, et);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Drive one beat and wait for its handshake; called just after a posedge.
  task automatic send(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l,
                      input logic [TW-1:0] t, output int waits);
    logic fired;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_typ   = t;
    waits    = 0;
    fired    = 1'b0;
    while (!fired) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
      if (!fired) begin
        waits++;
        if (waits > 500) begin
          checks++;
          errors++;
          $error("FAIL send_timeout obs=%0d exp=<500", waits);
          break;
        end
      end
    end
    if (fired) begin
      exp_beats.push_back('{data: d, keep: k, last: l});
      if (tb_first) exp_types.push_back(t);
      tb_first = l;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    ready_fixed    = 1'b1;
    rand_mode      = 1'b0;
    out_type_ready = 1'b1;
    n = 0;
    while ((exp_beats.size() != 0 || exp_types.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_beats", 32'(exp_beats.size()), 32'd0);
    chk("drain_types", 32'(exp_types.size()), 32'd0);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int w = 0; w < int'(DW / 32); w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] inc_data(input int i);
    logic [DW-1:0] d;
    for (int j = 0; j < int'(DB); j++) d[j*8 +: 8] = 8'(i + j);
    return d;
  endfunction

  initial begin
    int w;
    int tot;
    int tok0;
    logic [DB-1:0] kfull;
    kfull          = '1;
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_data        = '0;
    in_keep        = '0;
    in_last        = 1'b0;
    in_typ         = '0;
    out_ready      = 1'b1;
    out_type_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_type_valid", 32'(out_type_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single 3-beat packet.
    tok0 = tokens_seen;
    send(rnd_data(), kfull, 1'b0, T_A, w);
    chk("tok_latency", 32'(out_type_valid), 32'd1);
    chk("tok_latency_data", 32'(out_type_data), 32'(T_A));
    chk("beat_latency", 32'(out_valid), 32'd1);
    send(rnd_data(), 64'h00FF_00FF_00FF_00FF, 1'b0, T_A, w);
    send(rnd_data(), 64'h0000_0000_0000_000F, 1'b1, T_A, w);
    drain();
    chk("p1_tokens", 32'(tokens_seen - tok0), 32'd1);
    chk("p1_err", 32'(err), 32'd0);

    // Back-to-back single-beat packets, including an all-zero keep beat.
    tok0 = tokens_seen;
    tot  = 0;
    send(rnd_data(), kfull, 1'b1, T_A, w); tot += w;
    send(rnd_data(), '0,    1'b1, T_B, w); tot += w;
    send(rnd_data(), kfull, 1'b1, T_C, w); tot += w;
    chk("b2b_no_stall", 32'(tot), 32'd0);
    drain();
    chk("b2b_tokens", 32'(tokens_seen - tok0), 32'd3);

    // Type sink stalled: packet 2's first beat waits for token A to drain.
    out_type_ready = 1'b0;
    tot = 0;
    send(rnd_data(), kfull, 1'b0, T_A, w); tot += w;
    for (int i = 0; i < 2; i++) begin send(rnd_data(), kfull, 1'b0, T_A, w); tot += w; end
    send(rnd_data(), kfull, 1'b1, T_A, w); tot += w;
    chk("p1_flows", 32'(tot), 32'd0);
    in_valid = 1'b1;
    in_data  = rnd_data();
    in_keep  = kfull;
    in_last  = 1'b0;
    in_typ   = T_B;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("first_beat_blocked", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_type_ready = 1'b1;
    send(in_data, kfull, 1'b0, T_B, w);
    chk("first_beat_released", 32'(w), 32'd0);
    out_type_ready = 1'b0;
    tot = 0;
    for (int i = 0; i < 2; i++) begin send(rnd_data(), kfull, 1'b0, T_B, w); tot += w; end
    send(rnd_data(), kfull, 1'b1, T_B, w); tot += w;
    chk("body_no_type_wait", 32'(tot), 32'd0);
    drain();

    // 64-beat packet with random downstream ready.
    rand_mode = 1'b1;
    for (int i = 0; i < 64; i++) send(inc_data(i), kfull, 1'(i == 63), T_C, w);
    drain();

    // Mid-packet type mismatch.
    tok0 = tokens_seen;
    send(rnd_data(), kfull, 1'b0, T_A, w);
    send(rnd_data(), kfull, 1'b0, T_A, w);
    chk("err_before", 32'(err), 32'd0);
    send(rnd_data(), kfull, 1'b0, T_B, w);
    chk("err_rise", 32'(err), 32'd1);
    send(rnd_data(), kfull, 1'b1, T_A, w);
    drain();
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_one_token", 32'(tokens_seen - tok0), 32'd1);

    // Reset mid-packet with two beats buffered.
    ready_fixed    = 1'b0;
    out_type_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(rnd_data(), kfull, 1'b0, T_A, w);
    send(rnd_data(), kfull, 1'b0, T_A, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_beats.delete();
    exp_types.delete();
    tb_first = 1'b1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_type_valid", 32'(out_type_valid), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    ready_fixed    = 1'b1;
    out_type_ready = 1'b1;
    tok0 = tokens_seen;
    send(rnd_data(), kfull, 1'b1, T_C, w);
    drain();
    chk("rst_mid_tokens", 32'(tokens_seen - tok0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
